// File: rtl/serial_pkg.sv
// Shared definitions for the Lab4 serial link (receiver and transmitter).
// Holds the receive state encoding, default timing constants and the
// even-parity helper used when SERIAL_FRAME_RX_PARITY_EN is defined.
package serial_pkg;

  // Receive state machine encoding; PARITY is only entered when parity is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // 50 MHz system clock, 9600 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Even parity bit for a payload of up to 32 bits (zero-extend narrower payloads).
  function automatic logic even_parity(input logic [31:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period down-counter for the serial receiver.
// A load starts a half-bit or full-bit interval; tick pulses for one cycle
// when the interval expires. Reloading in the tick cycle chains intervals
// back to back without losing a cycle.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_LOAD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LOAD = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] count_reg;
  logic         active_reg;

  // Count down while active; stop at zero unless reloaded.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (load) begin
      count_reg  <= half ? HALF_LOAD : FULL_LOAD;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg == '0) begin
        active_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  assign tick = active_reg && (count_reg == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial byte receiver for the Lab4 single-wire link (8N1, or 8E1 when
// SERIAL_FRAME_RX_PARITY_EN is defined). The line is synchronized, frames are
// sampled at bit centres, and each good byte is held until rx_ack. Frame
// results are committed one cycle after the stop sample.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 M_CLOCK,
  input  logic                 M_RESET,
  input  logic                 inPin,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 sync1_reg;
  logic                 rx_line;
  logic                 prev_reg;
  logic                 fall;
  rx_state_t            state_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 done_reg;
  logic                 stop_ok_reg;
  logic                 frame_good;
  logic                 timer_load;
  logic                 timer_half;
  logic                 tick;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) begin
      sync1_reg <= 1'b1;
      rx_line   <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= inPin;
      rx_line   <= sync1_reg;
      prev_reg  <= rx_line;
    end
  end

  assign fall = prev_reg && !rx_line;

  // Start a half-bit wait on a start edge; chain full-bit waits after every
  // sample that is followed by another sample.
  assign timer_half = (state_reg == ST_IDLE);
  assign timer_load = ((state_reg == ST_IDLE) && fall) ||
                      (tick && (((state_reg == ST_START) && !rx_line) ||
                                (state_reg == ST_DATA) ||
                                (state_reg == ST_PARITY)));

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk (M_CLOCK),
    .srst(M_RESET),
    .load(timer_load),
    .half(timer_half),
    .tick(tick)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_ok_reg;
`endif

  // Frame state machine: walks start/data/[parity]/stop and flags completion.
  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) begin
      state_reg   <= ST_IDLE;
      busy        <= 1'b0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      done_reg    <= 1'b0;
      stop_ok_reg <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_ok_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fall) begin
            state_reg <= ST_START;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (!rx_line) begin
              state_reg   <= ST_DATA;
              bit_idx_reg <= '0;
            end else begin
              // Start bit vanished by mid-bit: treat as a line glitch.
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_reg <= {rx_line, shift_reg[DATA_BITS-1:1]};
            if (bit_idx_reg == LAST_IDX) begin
              bit_idx_reg <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state_reg   <= ST_PARITY;
`else
              state_reg   <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            par_ok_reg <= (rx_line == even_parity(32'(shift_reg)));
            state_reg  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            done_reg    <= 1'b1;
            stop_ok_reg <= rx_line;
            state_reg   <= ST_IDLE;
            busy        <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign frame_good = stop_ok_reg && par_ok_reg;
`else
  assign frame_good = stop_ok_reg;
`endif

  // Commit a finished frame into the holding register and update sticky flags.
  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done_reg && frame_good && (!rx_valid || rx_ack)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      // A setting event beats a simultaneous acknowledge.
      frame_err <= (done_reg && !stop_ok_reg) || (frame_err && !rx_ack);
      overrun   <= (done_reg && frame_good && rx_valid && !rx_ack) ||
                   (overrun && !rx_ack);
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  // Sticky parity flag, cleared by rx_ack unless a new mismatch arrives.
  always_ff @(posedge M_CLOCK) begin
    if (M_RESET) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (done_reg && !par_ok_reg) || (parity_err && !rx_ack);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (CLKS_PER_BIT=16, DATA_BITS=8).
// Define SERIAL_FRAME_RX_PARITY_EN for both RTL and bench to cover parity.
`timescale 1ns/1ps
module tb_serial_frame_rx;

  localparam int C = 16;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + C/2 + (8 + 1 + P) * C + 1;

  logic       clk = 1'b0;
  logic       M_RESET = 1'b0;
  logic       inPin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_count = 0;
  logic valid_q = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;
  exp_t sb[$];

  serial_frame_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .M_CLOCK   (clk),
    .M_RESET   (M_RESET),
    .inPin     (inPin),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard monitor: each rx_valid rise must match the oldest expected byte.
  always @(negedge clk) begin
    if (rx_valid && !valid_q) begin
      exp_t e;
      rise_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got rx_data=%02h with nothing expected", rx_data);
      end else begin
        e = sb.pop_front();
        if (rx_data !== e.data) begin
          errors++;
          $display("FAIL rx_data: got %02h expected %02h", rx_data, e.data);
        end
        checks++;
        if (cyc - e.start != LAT) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d", cyc - e.start, LAT);
        end
        $display("byte %02h delivered after %0d cycles", rx_data, cyc - e.start);
      end
    end
    valid_q = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    inPin = b;
    repeat (C) @(negedge clk);
  endtask

  // Sends one frame; when expect_good is set the byte is queued for the monitor.
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input bit expect_good);
    if (expect_good) sb.push_back('{data: d, start: cyc + 1});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) $display("note: parity argument unused");
`endif
    drive_bit(stop);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    M_RESET = 1'b1;
    inPin = 1'b1;
    repeat (3) @(negedge clk);
    M_RESET = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %02h expected 00", rx_data); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
    $display("reset: rx_valid=%b busy=%b flags=%b", rx_valid, busy, {frame_err, parity_err, overrun});
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, ^8'hA5, 1'b1, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b expected 0", busy); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
    do_ack();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got rx_valid=%b expected 0", rx_valid); end
    $display("single A5: acked, rx_valid=%b", rx_valid);
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b1);
    send_frame(8'hFF, ^8'hFF, 1'b1, 1'b0);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL overrun_data: got %02h expected 3c", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", rx_valid); end
    do_ack();
    checks++; if ({rx_valid, overrun} !== 2'b00) begin errors++; $display("FAIL overrun_ack: got valid,overrun=%b expected 00", {rx_valid, overrun}); end
    $display("overrun: data=%02h cleared after ack", rx_data);
  endtask

  task automatic test_frame_err();
    int busy_cycles = 0;
    send_frame(8'h55, ^8'h55, 1'b0, 1'b0);
    inPin = 1'b0;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    checks++; if (busy_cycles != 0) begin errors++; $display("FAIL held_low_retrigger: busy for %0d cycles expected 0", busy_cycles); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_flag: got %b expected 1", frame_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid: got %b expected 0", rx_valid); end
    inPin = 1'b1;
    repeat (2 * C) @(negedge clk);
    do_ack();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b expected 0", frame_err); end
    $display("frame error: flag set, byte dropped, cleared by ack");
  endtask

  task automatic test_glitch();
    bit busy_seen = 1'b0;
    inPin = 1'b0;
    repeat (4) @(negedge clk);
    inPin = 1'b1;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b expected 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    checks++; if ({rx_valid, frame_err, parity_err, overrun} !== 4'b0000) begin errors++; $display("FAIL glitch_state: got %b expected 0000", {rx_valid, frame_err, parity_err, overrun}); end
    $display("glitch: busy pulsed=%b, no flags", busy_seen);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h81;
    int rises_before;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    M_RESET = 1'b1;
    inPin = 1'b1;
    repeat (3) @(negedge clk);
    M_RESET = 1'b0;
    repeat (2 * C) @(negedge clk);
    checks++; if ({busy, rx_valid, frame_err, parity_err, overrun} !== 5'b00000) begin errors++; $display("FAIL midreset_state: got %b expected 00000", {busy, rx_valid, frame_err, parity_err, overrun}); end
    rises_before = rise_count;
    send_frame(8'h81, ^8'h81, 1'b1, 1'b1);
    repeat (C) @(negedge clk);
    checks++; if (rise_count - rises_before != 1) begin errors++; $display("FAIL midreset_rises: got %0d expected 1", rise_count - rises_before); end
    checks++; if ({frame_err, parity_err, overrun} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b expected 000", {frame_err, parity_err, overrun}); end
    do_ack();
    $display("mid-frame reset: recovered with %0d delivery", rise_count - rises_before);
  endtask

  task automatic test_back_to_back();
    bit ok;
    fork
      begin
        send_frame(8'h12, ^8'h12, 1'b1, 1'b1);
        send_frame(8'h34, ^8'h34, 1'b1, 1'b1);
      end
      begin
        wait_valid(LAT + 2 * C, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no rx_valid expected 1"); end
        do_ack();
      end
    join
    wait_valid(2 * C, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout: got no rx_valid expected 1"); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    do_ack();
    $display("back-to-back: two bytes delivered");
  endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_good_flag: got %b expected 0", parity_err); end
    do_ack();
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad_flag: got %b expected 1", parity_err); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL parity_bad_valid: got %b expected 0", rx_valid); end
    do_ack();
    $display("parity: good accepted, bad flagged");
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
`ifdef SERIAL_FRAME_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
